// File: rtl/spi_pkg.sv
// Shared SPI definitions: the master FSM state encoding and the default word
// width, which the companion SPI slave also takes from here.
package spi_pkg;

  localparam int SPI_DEFAULT_BC = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HI,
    LO,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period pacer: tick_o is high for one cycle out of every HALF cycles.
// The count restarts from zero on every cycle where clear_i is high.
module spi_half_tick #(
  parameter int HALF = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(HALF - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master. A single BC-bit shift register transmits MSB-first on
// mosi and collects miso at its LSB; every FSM phase lasts HALF clk cycles.
module spi_master
  import spi_pkg::*;
#(
  parameter int BC   = SPI_DEFAULT_BC,
  parameter int HALF = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [BC-1:0] din,
  output logic          busy,
  output logic          done,
  output logic [BC-1:0] dout,
  output logic          cs,
  output logic          sck,
  output logic          mosi,
  input  logic          miso
);

  localparam int NW = $clog2(BC + 1);

  spi_state_e    state_q, state_d;
  logic [BC-1:0] shift_q, shift_d;
  logic [BC-1:0] dout_q, dout_d;
  logic [NW-1:0] bitcnt_q, bitcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cs_q, cs_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          tick;
  logic          tick_clear;
  logic          in_xfer;

  // The pacer is held at zero in IDLE and restarted whenever the state changes.
  assign tick_clear = (state_q == IDLE) || (state_d != state_q);

  spi_half_tick #(
    .HALF(HALF)
  ) u_half_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(tick_clear),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = din;
          bitcnt_d = '0;
          state_d  = LEAD;
        end
      end
      LEAD: begin
        if (tick) state_d = HI;
      end
      HI: begin
        if (tick) begin
          shift_d  = {shift_q[BC-2:0], miso};
          bitcnt_d = bitcnt_q + NW'(1);
          state_d  = LO;
        end
      end
      LO: begin
        if (tick) begin
          if (bitcnt_q == NW'(BC)) begin
            dout_d  = shift_q;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            state_d = HI;
          end
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values are computed from the upcoming state so they register cleanly.
  always_comb begin
    in_xfer = (state_d == LEAD) || (state_d == HI) || (state_d == LO);
    cs_d    = !in_xfer;
    sck_d   = (state_d == HI);
    busy_d  = (state_d != IDLE);
    mosi_d  = in_xfer & shift_d[BC-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign cs   = cs_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule
